// File: rtl/mul_rs.sv
// Three-entry reservation station for the multiply/divide unit: captures operands from the CDB, dispatches one op at a time.
// Optional macro MUL_RS_AGE_EN: when defined, select is oldest-READY-first; otherwise lowest-index-READY-first.
module mul_rs #(
  parameter int DW = 8,
  parameter int TW = 3,
  parameter int N  = 3
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [3:0]    issue_func,
  input  logic [3:0]    issue_rd,
  input  logic [TW-1:0] issue_rob,
  input  logic          issue_v1,
  input  logic          issue_v2,
  input  logic [DW-1:0] issue_d1,
  input  logic [DW-1:0] issue_d2,
  input  logic [TW-1:0] issue_t1,
  input  logic [TW-1:0] issue_t2,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_rob,
  input  logic [DW-1:0] cdb_data,
  output logic          ex_b,
  output logic [2:0]    rs_index,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [3:0]    func,
  output logic [3:0]    rd,
  output logic [TW-1:0] rob_ind,
  input  logic          exec_done,
  input  logic [2:0]    done_index,
  output logic [1:0]    mulcount
);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_EXEC} st_t;

  st_t           r_st  [N];
  logic          r_v1  [N];
  logic          r_v2  [N];
  logic [DW-1:0] r_d1  [N];
  logic [DW-1:0] r_d2  [N];
  logic [TW-1:0] r_t1  [N];
  logic [TW-1:0] r_t2  [N];
  logic [3:0]    r_fn  [N];
  logic [3:0]    r_rdr [N];
  logic [TW-1:0] r_rob [N];
  logic          r_busy, r_rdy;
  logic [1:0]    r_cnt;

  st_t           w_st  [N];
  logic          w_v1  [N];
  logic          w_v2  [N];
  logic [DW-1:0] w_d1  [N];
  logic [DW-1:0] w_d2  [N];
  logic [TW-1:0] w_t1  [N];
  logic [TW-1:0] w_t2  [N];
  logic [3:0]    w_fn  [N];
  logic [3:0]    w_rdr [N];
  logic [TW-1:0] w_rob [N];
  logic          w_busy, w_rdy, w_issue, w_alloc_hit, w_sel_hit, w_disp, w_done;
  logic [2:0]    w_alloc_idx, w_sel_idx;
  logic [1:0]    w_cnt;
  logic [DW-1:0] w_o_d1, w_o_d2;
  logic [3:0]    w_o_fn, w_o_rd;
  logic [TW-1:0] w_o_rob;

  logic          r_ex_b;
  logic [2:0]    r_rs_index;
  logic [DW-1:0] r_rs1, r_rs2;
  logic [3:0]    r_func, r_rd;
  logic [TW-1:0] r_rob_ind;

`ifdef MUL_RS_AGE_EN
  logic [1:0] r_age [N];
  logic [1:0] w_age [N];
  logic [1:0] w_best;
`endif

  // Lowest FREE entry for allocation.
  always_comb begin
    w_alloc_hit = 1'b0;
    w_alloc_idx = 3'd0;
    for (int i = N-1; i >= 0; i--) begin
      if (r_st[i] == S_FREE) begin
        w_alloc_hit = 1'b1;
        w_alloc_idx = 3'(i);
      end
    end
  end

`ifdef MUL_RS_AGE_EN
  // Strict greater-than keeps the lower index on equal ages.
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_idx = 3'd0;
    w_best    = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (r_st[i] == S_READY && (!w_sel_hit || r_age[i] > w_best)) begin
        w_sel_hit = 1'b1;
        w_sel_idx = 3'(i);
        w_best    = r_age[i];
      end
    end
  end
`else
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_idx = 3'd0;
    for (int i = N-1; i >= 0; i--) begin
      if (r_st[i] == S_READY) begin
        w_sel_hit = 1'b1;
        w_sel_idx = 3'(i);
      end
    end
  end
`endif

  always_comb begin
    w_issue = issue_valid && r_rdy && w_alloc_hit;
    w_disp  = !r_busy && w_sel_hit;
    w_done  = 1'b0;
    w_o_d1  = '0;
    w_o_d2  = '0;
    w_o_fn  = '0;
    w_o_rd  = '0;
    w_o_rob = '0;
    for (int i = 0; i < N; i++) begin
      w_st[i]  = r_st[i];
      w_v1[i]  = r_v1[i];
      w_v2[i]  = r_v2[i];
      w_d1[i]  = r_d1[i];
      w_d2[i]  = r_d2[i];
      w_t1[i]  = r_t1[i];
      w_t2[i]  = r_t2[i];
      w_fn[i]  = r_fn[i];
      w_rdr[i] = r_rdr[i];
      w_rob[i] = r_rob[i];

      if (r_st[i] == S_WAIT && cdb_valid) begin
        if (!r_v1[i] && r_t1[i] == cdb_rob) begin
          w_v1[i] = 1'b1;
          w_d1[i] = cdb_data;
        end
        if (!r_v2[i] && r_t2[i] == cdb_rob) begin
          w_v2[i] = 1'b1;
          w_d2[i] = cdb_data;
        end
        if (w_v1[i] && w_v2[i]) w_st[i] = S_READY;
      end

      if (w_disp && w_sel_idx == 3'(i)) begin
        w_st[i] = S_EXEC;
        w_o_d1  = r_d1[i];
        w_o_d2  = r_d2[i];
        w_o_fn  = r_fn[i];
        w_o_rd  = r_rdr[i];
        w_o_rob = r_rob[i];
      end

      // Completion against a non-EXEC entry (stale or bogus) is dropped entirely.
      if (exec_done && done_index == 3'(i) && r_st[i] == S_EXEC) begin
        w_st[i] = S_FREE;
        w_done  = 1'b1;
      end

      if (w_issue && w_alloc_idx == 3'(i)) begin
        w_fn[i]  = issue_func;
        w_rdr[i] = issue_rd;
        w_rob[i] = issue_rob;
        w_t1[i]  = issue_t1;
        w_t2[i]  = issue_t2;
        w_v1[i]  = issue_v1 || (cdb_valid && cdb_rob == issue_t1);
        w_v2[i]  = issue_v2 || (cdb_valid && cdb_rob == issue_t2);
        w_d1[i]  = issue_v1 ? issue_d1 : cdb_data;
        w_d2[i]  = issue_v2 ? issue_d2 : cdb_data;
        w_st[i]  = (w_v1[i] && w_v2[i]) ? S_READY : S_WAIT;
      end
    end

    w_busy = r_busy;
    if (w_done) w_busy = 1'b0;
    if (w_disp) w_busy = 1'b1;

    w_cnt = 2'd0;
    w_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_st[i] != S_FREE) w_cnt = w_cnt + 2'd1;
      else                   w_rdy = 1'b1;
    end
  end

`ifdef MUL_RS_AGE_EN
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_age[i] = r_age[i];
      if (w_issue) begin
        if (w_alloc_idx == 3'(i))                       w_age[i] = 2'd0;
        else if (r_st[i] != S_FREE && r_age[i] != 2'd3) w_age[i] = r_age[i] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk2) begin
    for (int i = 0; i < N; i++) r_age[i] <= rst ? 2'd0 : w_age[i];
  end
`endif

  always_ff @(posedge clk2) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_st[i]  <= S_FREE;
        r_v1[i]  <= 1'b0;
        r_v2[i]  <= 1'b0;
        r_d1[i]  <= '0;
        r_d2[i]  <= '0;
        r_t1[i]  <= '0;
        r_t2[i]  <= '0;
        r_fn[i]  <= '0;
        r_rdr[i] <= '0;
        r_rob[i] <= '0;
      end
      r_busy     <= 1'b0;
      r_rdy      <= 1'b0;
      r_cnt      <= 2'd0;
      r_ex_b     <= 1'b0;
      r_rs_index <= 3'd0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_func     <= '0;
      r_rd       <= '0;
      r_rob_ind  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_st[i]  <= w_st[i];
        r_v1[i]  <= w_v1[i];
        r_v2[i]  <= w_v2[i];
        r_d1[i]  <= w_d1[i];
        r_d2[i]  <= w_d2[i];
        r_t1[i]  <= w_t1[i];
        r_t2[i]  <= w_t2[i];
        r_fn[i]  <= w_fn[i];
        r_rdr[i] <= w_rdr[i];
        r_rob[i] <= w_rob[i];
      end
      r_busy <= w_busy;
      r_rdy  <= w_rdy;
      r_cnt  <= w_cnt;
      r_ex_b <= w_disp;
      if (w_disp) begin
        r_rs_index <= w_sel_idx;
        r_rs1      <= w_o_d1;
        r_rs2      <= w_o_d2;
        r_func     <= w_o_fn;
        r_rd       <= w_o_rd;
        r_rob_ind  <= w_o_rob;
      end
    end
  end

  assign issue_ready = r_rdy;
  assign mulcount    = r_cnt;
  assign ex_b        = r_ex_b;
  assign rs_index    = r_rs_index;
  assign rs1_data    = r_rs1;
  assign rs2_data    = r_rs2;
  assign func        = r_func;
  assign rd          = r_rd;
  assign rob_ind     = r_rob_ind;

endmodule

// File: tb/tb_mul_rs.sv
// Directed bench for mul_rs: issue, CDB wake-up/bypass, full station, select policy, mid-run reset.
module tb_mul_rs;
  logic       clk2 = 1'b0;
  logic       rst, issue_valid, issue_ready, issue_v1, issue_v2, cdb_valid, ex_b, exec_done;
  logic [3:0] issue_func, issue_rd, func, rd;
  logic [2:0] issue_rob, issue_t1, issue_t2, cdb_rob, rs_index, rob_ind, done_index;
  logic [7:0] issue_d1, issue_d2, cdb_data, rs1_data, rs2_data;
  logic [1:0] mulcount;
  int n_chk = 0, n_pass = 0;

  // {ex_b, rs_index, rs1, rs2, func, rd, rob_ind, mulcount, issue_ready}
  logic [33:0] obs;
  assign obs = {ex_b, rs_index, rs1_data, rs2_data, func, rd, rob_ind, mulcount, issue_ready};

  mul_rs #(.DW(8), .TW(3), .N(3)) dut (
    .clk2(clk2), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_func(issue_func), .issue_rd(issue_rd), .issue_rob(issue_rob),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_d1(issue_d1), .issue_d2(issue_d2),
    .issue_t1(issue_t1), .issue_t2(issue_t2), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_data(cdb_data), .ex_b(ex_b), .rs_index(rs_index), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .func(func), .rd(rd), .rob_ind(rob_ind), .exec_done(exec_done),
    .done_index(done_index), .mulcount(mulcount)
  );

  always #5 clk2 = ~clk2;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob,
                           input logic v1, input logic [7:0] d1, input logic [2:0] t1,
                           input logic v2, input logic [7:0] d2, input logic [2:0] t2);
    issue_valid = 1'b1; issue_func = f; issue_rd = r; issue_rob = rob;
    issue_v1 = v1; issue_d1 = d1; issue_t1 = t1;
    issue_v2 = v2; issue_d2 = d2; issue_t2 = t2;
  endtask

  task automatic do_issue(input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob,
                          input logic v1, input logic [7:0] d1, input logic [2:0] t1,
                          input logic v2, input logic [7:0] d2, input logic [2:0] t2);
    set_issue(f, r, rob, v1, d1, t1, v2, d2, t2);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic do_done(input logic [2:0] idx);
    exec_done = 1'b1; done_index = idx;
    step();
    exec_done = 1'b0;
  endtask

  task automatic do_cdb(input logic [2:0] tag, input logic [7:0] d);
    cdb_valid = 1'b1; cdb_rob = tag; cdb_data = d;
    step();
    cdb_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    n_chk++;
    if (obs !== 34'd0) $display("FAIL reset_hold obs=%h exp=%h", obs, 34'd0); else n_pass++;
    rst = 1'b0;
    step();
    n_chk++;
    if (obs !== 34'd1) $display("FAIL reset_release obs=%h exp=%h", obs, 34'd1); else n_pass++;
  endtask

  task automatic test_mul_basic;
    do_issue(4'b0010, 4'd4, 3'd3, 1'b1, 8'd5, 3'd0, 1'b1, 8'd7, 3'd0);
    n_chk++;
    if (obs !== {1'b0, 3'd0, 8'd0, 8'd0, 4'd0, 4'd0, 3'd0, 2'd1, 1'b1})
      $display("FAIL mul_issue obs=%h", obs); else n_pass++;
    step();
    n_chk++;
    if (obs !== {1'b1, 3'd0, 8'd5, 8'd7, 4'b0010, 4'd4, 3'd3, 2'd1, 1'b1})
      $display("FAIL mul_dispatch obs=%h exp=%h", obs, {1'b1, 3'd0, 8'd5, 8'd7, 4'b0010, 4'd4, 3'd3, 2'd1, 1'b1});
    else n_pass++;
    step();
    n_chk++;
    if (obs !== {1'b0, 3'd0, 8'd5, 8'd7, 4'b0010, 4'd4, 3'd3, 2'd1, 1'b1})
      $display("FAIL mul_hold obs=%h", obs); else n_pass++;
    do_done(3'd0);
    n_chk++;
    if (mulcount !== 2'd0) $display("FAIL mul_done mulcount=%0d exp=0", mulcount); else n_pass++;
  endtask

  task automatic test_wakeup;
    do_issue(4'b0011, 4'd6, 3'd2, 1'b1, 8'd20, 3'd0, 1'b0, 8'd0, 3'd5);
    do_cdb(3'd4, 8'd99);
    step();
    n_chk++;
    if (ex_b !== 1'b0) $display("FAIL wake_wrong_tag ex_b=%0b exp=0", ex_b); else n_pass++;
    do_cdb(3'd5, 8'd3);
    n_chk++;
    if (ex_b !== 1'b0) $display("FAIL wake_early ex_b=%0b exp=0", ex_b); else n_pass++;
    step();
    n_chk++;
    if (obs !== {1'b1, 3'd0, 8'd20, 8'd3, 4'b0011, 4'd6, 3'd2, 2'd1, 1'b1})
      $display("FAIL wake_dispatch obs=%h", obs); else n_pass++;
    do_done(3'd0);
  endtask

  task automatic test_bypass;
    cdb_valid = 1'b1; cdb_rob = 3'd6; cdb_data = 8'd3;
    do_issue(4'b1111, 4'd9, 3'd1, 1'b0, 8'd0, 3'd6, 1'b1, 8'd9, 3'd0);
    cdb_valid = 1'b0;
    step();
    n_chk++;
    if (obs !== {1'b1, 3'd0, 8'd3, 8'd9, 4'b1111, 4'd9, 3'd1, 2'd1, 1'b1})
      $display("FAIL bypass obs=%h", obs); else n_pass++;
    do_done(3'd0);
  endtask

  task automatic test_back_to_back;
    do_issue(4'b0010, 4'd1, 3'd4, 1'b1, 8'd1, 3'd0, 1'b1, 8'd2, 3'd0);
    do_issue(4'b0111, 4'd2, 3'd5, 1'b1, 8'd3, 3'd0, 1'b1, 8'd4, 3'd0);
    // entry 0 dispatched on the second issue edge; bogus done for entry 1 (READY) is ignored
    do_done(3'd1);
    step();
    n_chk++;
    if (ex_b !== 1'b0 || mulcount !== 2'd2)
      $display("FAIL b2b_bogus_done ex_b=%0b mulcount=%0d exp ex_b=0 mulcount=2", ex_b, mulcount);
    else n_pass++;
    do_done(3'd0);
    n_chk++;
    if (ex_b !== 1'b0) $display("FAIL b2b_same_edge ex_b=%0b exp=0", ex_b); else n_pass++;
    step();
    n_chk++;
    if (obs !== {1'b1, 3'd1, 8'd3, 8'd4, 4'b0111, 4'd2, 3'd5, 2'd1, 1'b1})
      $display("FAIL b2b_second obs=%h", obs); else n_pass++;
    do_done(3'd1);
  endtask

  task automatic test_full;
    logic [2:0] exp_idx, exp_rob;
    do_issue(4'b0010, 4'd1, 3'd1, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    do_issue(4'b0010, 4'd2, 3'd2, 1'b1, 8'd2, 3'd0, 1'b1, 8'd2, 3'd0);
    do_issue(4'b0010, 4'd3, 3'd3, 1'b1, 8'd3, 3'd0, 1'b1, 8'd3, 3'd0);
    set_issue(4'b0011, 4'd7, 3'd7, 1'b1, 8'd7, 3'd0, 1'b1, 8'd7, 3'd0);
    step(2);
    n_chk++;
    if (issue_ready !== 1'b0 || mulcount !== 2'd3)
      $display("FAIL full_stall ready=%0b mulcount=%0d exp ready=0 mulcount=3", issue_ready, mulcount);
    else n_pass++;
    exec_done = 1'b1; done_index = 3'd0;
    step();
    exec_done = 1'b0;
    n_chk++;
    if (issue_ready !== 1'b1 || mulcount !== 2'd2)
      $display("FAIL full_free ready=%0b mulcount=%0d exp ready=1 mulcount=2", issue_ready, mulcount);
    else n_pass++;
    step();
    issue_valid = 1'b0;
    n_chk++;
    if (ex_b !== 1'b1 || rs_index !== 3'd1 || mulcount !== 2'd3 || issue_ready !== 1'b0)
      $display("FAIL full_realloc ex_b=%0b idx=%0d mulcount=%0d ready=%0b exp 1/1/3/0",
               ex_b, rs_index, mulcount, issue_ready);
    else n_pass++;
    do_done(3'd1);
    step();
`ifdef MUL_RS_AGE_EN
    exp_idx = 3'd2; exp_rob = 3'd3;
`else
    exp_idx = 3'd0; exp_rob = 3'd7;
`endif
    n_chk++;
    if (ex_b !== 1'b1 || rs_index !== exp_idx || rob_ind !== exp_rob)
      $display("FAIL full_next ex_b=%0b idx=%0d rob=%0d exp 1/%0d/%0d", ex_b, rs_index, rob_ind, exp_idx, exp_rob);
    else n_pass++;
    do_done(exp_idx);
    step();
    do_done(rs_index);
    n_chk++;
    if (mulcount !== 2'd0) $display("FAIL full_drain mulcount=%0d exp=0", mulcount); else n_pass++;
  endtask

  task automatic test_select;
    logic [2:0] exp_idx;
    do_issue(4'b0010, 4'd1, 3'd0, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    do_issue(4'b0010, 4'd2, 3'd1, 1'b0, 8'd0, 3'd1, 1'b1, 8'd2, 3'd0);
    do_issue(4'b0010, 4'd3, 3'd2, 1'b0, 8'd0, 3'd2, 1'b1, 8'd3, 3'd0);
    do_done(3'd0);
    do_issue(4'b0010, 4'd4, 3'd3, 1'b0, 8'd0, 3'd3, 1'b1, 8'd4, 3'd0);
    do_cdb(3'd1, 8'd11);
    step();
    n_chk++;
    if (ex_b !== 1'b1 || rs_index !== 3'd1) $display("FAIL sel_first ex_b=%0b idx=%0d exp 1/1", ex_b, rs_index);
    else n_pass++;
    do_cdb(3'd2, 8'd22);
    do_cdb(3'd3, 8'd33);
    do_done(3'd1);
    step();
`ifdef MUL_RS_AGE_EN
    exp_idx = 3'd2;
`else
    exp_idx = 3'd0;
`endif
    n_chk++;
    if (ex_b !== 1'b1 || rs_index !== exp_idx)
      $display("FAIL sel_policy ex_b=%0b idx=%0d exp 1/%0d", ex_b, rs_index, exp_idx);
    else n_pass++;
    n_chk++;
    if (rs1_data !== ((exp_idx == 3'd2) ? 8'd22 : 8'd33))
      $display("FAIL sel_data rs1=%0d", rs1_data); else n_pass++;
    do_done(exp_idx);
    step();
    do_done(rs_index);
  endtask

  task automatic test_reset_mid;
    do_issue(4'b0011, 4'd5, 3'd6, 1'b1, 8'd8, 3'd0, 1'b1, 8'd2, 3'd0);
    step();
    n_chk++;
    if (ex_b !== 1'b1) $display("FAIL rmid_pre ex_b=%0b exp=1", ex_b); else n_pass++;
    rst = 1'b1;
    step();
    n_chk++;
    if (obs !== 34'd0) $display("FAIL rmid_reset obs=%h exp=0", obs); else n_pass++;
    rst = 1'b0;
    step();
    do_done(3'd0);
    n_chk++;
    if (obs !== 34'd1) $display("FAIL rmid_stale_done obs=%h exp=1", obs); else n_pass++;
    do_issue(4'b0010, 4'd3, 3'd2, 1'b1, 8'd6, 3'd0, 1'b1, 8'd6, 3'd0);
    step();
    n_chk++;
    if (obs !== {1'b1, 3'd0, 8'd6, 8'd6, 4'b0010, 4'd3, 3'd2, 2'd1, 1'b1})
      $display("FAIL rmid_after obs=%h", obs); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_func = '0; issue_rd = '0; issue_rob = '0;
    issue_v1 = 1'b0; issue_v2 = 1'b0; issue_d1 = '0; issue_d2 = '0; issue_t1 = '0; issue_t2 = '0;
    cdb_valid = 1'b0; cdb_rob = '0; cdb_data = '0; exec_done = 1'b0; done_index = '0;
    test_reset;
    test_mul_basic;
    test_wakeup;
    test_bypass;
    test_back_to_back;
    test_full;
    test_select;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
